// File: rtl/ls_pkg.sv
// Load/store unit shared types: func3 codes, FSM states, size decode.
// Imported by ls_unit and ls_lane_align.
package ls_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } st_f3_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    DONE
  } ls_state_e;

  function automatic logic [3:0] size_mask(
    input logic [1:0] sz
  );
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    if (we)
      ok = f3 inside {SB, SH, SW};
    else
      ok = f3 inside {LB, LH, LW, LBU, LHU};
    return ok;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane steering for the load/store unit: enables, store
// rotation and load extract/extend. Purely combinational.
module ls_lane_align
  import ls_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [23:0] word1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic        split,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata
);

  logic [7:0]  mask;
  logic [31:0] raw;

  assign mask  = {4'b0000, size_mask(func3[1:0])} << off;
  assign be0   = mask[3:0];
  assign be1   = mask[7:4];
  assign split = |mask[7:4];

  always_comb begin
    wdata_rot = wdata;
    raw       = word0;
    case (off)
      2'd1: begin
        wdata_rot = {wdata[23:0], wdata[31:24]};
        raw       = {word1[7:0], word0[31:8]};
      end
      2'd2: begin
        wdata_rot = {wdata[15:0], wdata[31:16]};
        raw       = {word1[15:0], word0[31:16]};
      end
      2'd3: begin
        wdata_rot = {wdata[7:0], wdata[31:8]};
        raw       = {word1[23:0], word0[31:24]};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = raw;
    unique case (1'b1)
      (func3 == LB):  rdata = {{24{raw[7]}}, raw[7:0]};
      (func3 == LH):  rdata = {{16{raw[15]}}, raw[15:0]};
      (func3 == LBU): rdata = {24'h0, raw[7:0]};
      (func3 == LHU): rdata = {16'h0, raw[15:0]};
      default:        rdata = raw;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// MEM-stage load/store unit: one request at a time, word-boundary
// crossing accesses split into two memory cycles.
module ls_unit
  import ls_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WI_W = ADDR_W - 2;

  ls_state_e state, state_nx;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       word0_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_nx;

  logic [WI_W-1:0]   widx;
  logic [3:0]        be0, be1;
  logic              split;
  logic [31:0]       wrot, ld_data, w0;
  logic              hs;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];
  assign hs   = req_valid && req_ready;
  assign widx = addr_q[ADDR_W-1:2];
  // Split loads park the first word; the second arrives live in DONE.
  assign w0   = split ? word0_q : mem_rdata;

  ls_lane_align u_align (
    .func3     (f3_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .word0     (w0),
    .word1     (mem_rdata[23:0]),
    .be0       (be0),
    .be1       (be1),
    .split     (split),
    .wdata_rot (wrot),
    .rdata     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word0_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (hs) begin
        we_q    <= req_we;
        f3_q    <= req_func3;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        err_q   <= !f3_legal(req_we, req_func3);
      end
      if (state == ACC1)
        word0_q <= mem_rdata;
      if (state == DONE)
        rdata_q <= rdata_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    rdata_nx   = rdata_q;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid)
            state_nx = f3_legal(req_we, req_func3) ? ACC0 : DONE;
        end
        ACC0: begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = widx;
          mem_be    = be0;
          mem_wdata = wrot;
          state_nx  = split ? ACC1 : DONE;
        end
        ACC1: begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = widx + WI_W'(1);
          mem_be    = be1;
          mem_wdata = wrot;
          state_nx  = DONE;
        end
        DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          rdata_nx   = (we_q || err_q) ? 32'h0 : ld_data;
          state_nx   = IDLE;
        end
      endcase
    end
  end

  assign resp_rdata = rst ? 32'h0 : rdata_nx;

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: byte-array memory, byte-level reference model,
// directed cases plus randomized requests.
module tb_ls_unit;

  localparam int AW = 11;
  localparam int MB = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ls_unit #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [7:0] mem     [MB];
  logic [7:0] ref_mem [MB];

  int tests = 0;
  int fails = 0;

  logic        obs_en   [8];
  logic [8:0]  obs_addr [8];
  logic [3:0]  obs_be   [8];
  logic [31:0] obs_wd   [8];

  always @(posedge clk) begin
    mem_rdata <= {mem[{mem_addr, 2'd3}], mem[{mem_addr, 2'd2}],
                  mem[{mem_addr, 2'd1}], mem[{mem_addr, 2'd0}]};
    if (mem_en && mem_we)
      for (int k = 0; k < 4; k++)
        if (mem_be[k])
          mem[{mem_addr, k[1:0]}] <= mem_wdata[8*k +: 8];
  end

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int m_idx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'h7FF);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int n = m_size(f3);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[m_idx(a, i)];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < m_size(f3); i++) ref_mem[m_idx(a, i)] = wd[8*i +: 8];
  endtask

  function automatic int m_lat(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!m_legal(we, f3)) return 1;
    return (int'(a[1:0]) + m_size(f3) > 4) ? 3 : 2;
  endfunction

  task automatic poke(input int a, input logic [7:0] b);
    mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output logic err, output int n_en);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat  = 99;
    rd   = 32'h0;
    err  = 1'b0;
    n_en = 0;
    for (int c = 1; c <= 6; c++) begin
      obs_en[c]   = mem_en;
      obs_addr[c] = mem_addr;
      obs_be[c]   = mem_be;
      obs_wd[c]   = mem_wdata;
      if (mem_en) n_en++;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_func3 = 3'd2;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_en} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000", {req_ready, resp_valid, resp_err, mem_en});
    end
    tests++;
    if (resp_rdata !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      fails++;
      $display("FAIL reset_data: got rdata %h wdata %h be %h want 0", resp_rdata, mem_wdata, mem_be);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_aligned();
    int lat, n;
    logic [31:0] rd;
    logic err;
    run_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, lat, rd, err, n);
    m_store(3'd2, 32'h010, 32'hDEADBEEF);
    tests++;
    if (lat !== 2 || obs_addr[1] !== 9'h004 || obs_be[1] !== 4'hF || obs_wd[1] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_aligned: got lat %0d addr %h be %h wd %h want 2 004 f deadbeef",
               lat, obs_addr[1], obs_be[1], obs_wd[1]);
    end
    run_req(1'b0, 3'd2, 32'h010, 32'h0, lat, rd, err, n);
    tests++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      fails++;
      $display("FAIL lw_aligned: got lat %0d rd %h err %b want 2 deadbeef 0", lat, rd, err);
    end
  endtask

  task automatic test_extend();
    int lat, n;
    logic [31:0] rd;
    logic err;
    logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] as  [3] = '{32'h013, 32'h013, 32'h012};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000};
    poke(16, 8'h00); poke(17, 8'h00); poke(18, 8'h00); poke(19, 8'h80);
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, f3s[i], as[i], 32'h0, lat, rd, err, n);
      tests++;
      if (lat !== 2 || rd !== exp[i]) begin
        fails++;
        $display("FAIL extend_%0d: got lat %0d rd %h want 2 %h", i, lat, rd, exp[i]);
      end
    end
  endtask

  task automatic test_split();
    int lat, n;
    logic [31:0] rd;
    logic err;
    run_req(1'b1, 3'd2, 32'h012, 32'h11223344, lat, rd, err, n);
    m_store(3'd2, 32'h012, 32'h11223344);
    tests++;
    if (lat !== 3 || obs_addr[1] !== 9'h004 || obs_be[1] !== 4'hC || obs_wd[1] !== 32'h33441122) begin
      fails++;
      $display("FAIL split_acc0: got lat %0d addr %h be %h wd %h want 3 004 c 33441122",
               lat, obs_addr[1], obs_be[1], obs_wd[1]);
    end
    tests++;
    if (obs_en[2] !== 1'b1 || obs_addr[2] !== 9'h005 || obs_be[2] !== 4'h3 || obs_wd[2] !== 32'h33441122) begin
      fails++;
      $display("FAIL split_acc1: got en %b addr %h be %h wd %h want 1 005 3 33441122",
               obs_en[2], obs_addr[2], obs_be[2], obs_wd[2]);
    end
    run_req(1'b0, 3'd2, 32'h012, 32'h0, lat, rd, err, n);
    tests++;
    if (lat !== 3 || rd !== 32'h11223344) begin
      fails++;
      $display("FAIL split_lw: got lat %0d rd %h want 3 11223344", lat, rd);
    end
  endtask

  task automatic test_wrap();
    int lat, n;
    logic [31:0] rd;
    logic err;
    poke(2047, 8'h34);
    poke(0, 8'h92);
    run_req(1'b0, 3'd1, 32'h7FF, 32'h0, lat, rd, err, n);
    tests++;
    if (obs_addr[1] !== 9'h1FF || obs_be[1] !== 4'h8 || obs_addr[2] !== 9'h000 || obs_be[2] !== 4'h1) begin
      fails++;
      $display("FAIL wrap_acc: got %h/%h %h/%h want 1ff/8 000/1",
               obs_addr[1], obs_be[1], obs_addr[2], obs_be[2]);
    end
    tests++;
    if (lat !== 3 || rd !== 32'hFFFF9234) begin
      fails++;
      $display("FAIL wrap_lh: got lat %0d rd %h want 3 ffff9234", lat, rd);
    end
  endtask

  task automatic test_illegal();
    int lat, n;
    logic [31:0] rd;
    logic err;
    run_req(1'b0, 3'd3, 32'h020, 32'h0, lat, rd, err, n);
    tests++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || n !== 0) begin
      fails++;
      $display("FAIL illegal_load: got lat %0d err %b rd %h en %0d want 1 1 0 0", lat, err, rd, n);
    end
    run_req(1'b1, 3'd4, 32'h020, 32'hCAFEF00D, lat, rd, err, n);
    tests++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || n !== 0) begin
      fails++;
      $display("FAIL illegal_store: got lat %0d err %b rd %h en %0d want 1 1 0 0", lat, err, rd, n);
    end
  endtask

  task automatic test_random();
    int lat, n, elat, en_exp;
    logic [31:0] rd, a, wd, erd, lo;
    logic err, we;
    logic [2:0] f3;
    for (int it = 0; it < 200; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(2040, 2047))
                                        : 32'($urandom_range(0, 63));
      a  = ($urandom() & 32'hFFFFF800) | lo;
      wd = $urandom();
      elat = m_lat(we, f3, a);
      en_exp = (elat == 1) ? 0 : elat - 1;
      erd = (!we && m_legal(we, f3)) ? m_load(f3, a) : 32'h0;
      run_req(we, f3, a, wd, lat, rd, err, n);
      if (we && m_legal(we, f3)) m_store(f3, a, wd);
      tests++;
      if (lat !== elat || n !== en_exp || err !== !m_legal(we, f3) || rd !== erd) begin
        fails++;
        $display("FAIL random_%0d: we %b f3 %0d a %h got lat %0d en %0d err %b rd %h want %0d %0d %b %h",
                 it, we, f3, a, lat, n, err, rd, elat, en_exp, !m_legal(we, f3), erd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int i = 16; i < 24; i++) poke(i, 8'hA0 + 8'(i));
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'd2;
    req_addr  = 32'h012;
    req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (mem_en !== 1'b0 || resp_valid !== 1'b0) bad++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_en !== 1'b0 || resp_valid !== 1'b0) bad++;
    end
    ref_mem[18] = 8'h44;
    ref_mem[19] = 8'h33;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_abort: got %0d cycles with activity want 0", bad);
    end
    tests++;
    if ({mem[19], mem[18], mem[21], mem[20]} !== {8'h33, 8'h44, ref_mem[21], ref_mem[20]}) begin
      fails++;
      $display("FAIL rst_partial: got %h%h %h%h want 3344 %h%h",
               mem[19], mem[18], mem[21], mem[20], ref_mem[21], ref_mem[20]);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_ready: got ready %b rdata %h want 1 0", req_ready, resp_rdata);
    end
  endtask

  task automatic test_mem_sweep();
    int first = -1;
    for (int i = 0; i < MB; i++)
      if (mem[i] !== ref_mem[i] && first < 0) first = i;
    tests++;
    if (first >= 0) begin
      fails++;
      $display("FAIL mem_sweep: byte %h got %h want %h", first, mem[first], ref_mem[first]);
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin
      logic [7:0] b;
      b = 8'($urandom());
      mem[i] = b;
      ref_mem[i] = b;
    end
    test_reset();
    test_aligned();
    test_extend();
    test_split();
    test_wrap();
    test_illegal();
    test_random();
    test_reset_mid();
    test_mem_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ls_unit.md
# ls_unit

Load/store unit for the MEM stage of the pipeline. It is the initiator on the data-memory port: it takes one RISC-V load or store per request and drives a word-organized, byte-enabled memory with 1-cycle read latency. Accesses that cross a word boundary are split into two memory accesses. Load data comes back sign- or zero-extended per func3.

## Interface
- ADDR_W, 11, byte-address width; 2 KiB data memory. Word index is ADDR_W-2 bits.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  loads: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores: SB 000, SH 001, SW 010
- req_addr  in  32  effective byte address; bits above ADDR_W-1 ignored
- req_wdata  in  32  store data; bytes taken from the LSB upward
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal func3; qualified by resp_valid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write when mem_en
- mem_addr  out  ADDR_W-2  word index
- mem_be  out  4  byte-lane enables, lane k = bits [8k+7:8k]
- mem_wdata  out  32  write data, lane-aligned
- mem_rdata  in  32  read word; valid the cycle after a read access

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - req_ready = 1.
  - On handshake, register we, func3, addr[ADDR_W-1:0] and wdata.
  - Legal func3 -> ACC0. Illegal func3 -> DONE with err flag set.
  - Illegal codes: loads 011/110/111; stores 011–111.
- Size n = 1/2/4 from func3[1:0]; offset o = addr[1:0].
- ACC0:
  - mem_en = 1, mem_addr = addr[ADDR_W-1:2].
  - mem_be has lanes o..min(o+n-1, 3) set.
  - If o+n > 4, go to ACC1; otherwise go to DONE.
- ACC1:
  - mem_en = 1, mem_addr = word index + 1, modulo 2^(ADDR_W-2). Address 0x7FF wraps to word 0.
  - mem_be has lanes 0..o+n-5 set.
  - Capture mem_rdata as word0. Go to DONE.
- Store data: mem_wdata = req_wdata rotated left by 8*o in both accesses; mem_be selects the lanes.
- Load data:
  - Single access: word0 = mem_rdata in DONE.
  - Split access: word1 = mem_rdata in DONE.
  - Result = ({word1, word0} >> 8*o), truncated to n bytes.
  - LB/LH sign-extend; LBU/LHU/LW zero-extend.
- DONE:
  - resp_valid = 1; resp_err and resp_rdata valid.
  - Go to IDLE.
- req_valid outside IDLE is ignored. The pipeline holds the request until req_ready.
- Reset:
  - Every output is 0 while rst is high; resp_rdata register is cleared to 0.
  - Next state is IDLE, so req_ready = 1 on the first cycle after rst falls.
  - Reset mid-operation aborts the request: no resp_valid, and no further mem_en for it.
  - A half-completed split store, with ACC0 already written, is not rolled back.
- resp_rdata holds its value until the next DONE. mem_wdata/mem_be are don't-care when mem_en = 0; the RTL drives them to 0.

## Timing
- Handshake at edge T. All latencies below are counted from that edge.

| Request | Memory accesses | resp_valid |
|---|---|---|
| Aligned (o+n ≤ 4) | ACC0 in cycle T+1 | T+2 |
| Split (o+n > 4) | ACC0 at T+1, ACC1 at T+2 | T+3 |
| Illegal func3 | none | T+1 |

- req_ready returns 1 on the cycle after resp_valid. Peak throughput is one request every 3 cycles (aligned) or 4 cycles (split).
- Memory contract: a write commits on the rising edge at the end of the mem_en cycle. A read presents mem_rdata the following cycle.

## Structure
- Package ls_pkg holds:
  - load/store func3 enums, shared with the decode header rv_dec.svh;
  - state enum (IDLE/ACC0/ACC1/DONE);
  - size-decode function;
  - ADDR_W default.
- Sub-module ls_lane_align (combinational) handles:
  - byte-enable generation for both accesses;
  - store rotation;
  - load extract and extend from {word1, word0}, o, and func3.
- ls_unit keeps only the FSM, the request registers and the word0 capture.

## Test plan
- SW 0x010, wdata 0xDEADBEEF -> T+1: mem_addr 0x004, be 1111, mem_wdata 0xDEADBEEF. Then LW 0x010 -> resp_rdata 0xDEADBEEF at T+2.
- Memory word 4 = 0x80000000: LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; LH 0x012 -> 0xFFFF8000.
- SW 0x012, wdata 0x11223344:
  - ACC0: word 4, be 1100, wdata 0x33441122.
  - ACC1: word 5, be 0011, wdata 0x33441122.
  - resp_valid at T+3. A following LW 0x012 returns 0x11223344 at T+3.
- Byte 0x7FF = 0x34, byte 0x000 = 0x92; LH 0x7FF:
  - ACC0: word 0x1FF, be 1000.
  - ACC1: word 0x000, be 0001.
  - resp_rdata 0xFFFF9234.
- Load with func3 011 -> no mem_en; at T+1 resp_valid = 1, resp_err = 1, resp_rdata = 0. Store with func3 100 behaves the same.
- rst high during ACC1 of the split store above -> mem_en 0 from the next cycle, no resp_valid, word 4 already updated. req_ready = 1 on the first cycle after rst falls.
